// File: rtl/shift_mac_array.sv
// shift_mac_array
//   Multi-lane log-weight multiply-accumulate. Each lane multiplies an
//   unsigned activation by a sign+exponent weight using a shift and an
//   optional two's-complement negate. The lane products are summed and
//   accumulated with saturation over a group of beats that ends with i_last.
//   Three stages: S1 lane products, S2 lane sum, S3 accumulator/result.
//   A single stall signal (advance) freezes every stage under backpressure.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   i_valid / o_ready  input beat handshake (o_ready = advance)
//   i_weight           LANES x (EXP_W+1): lane k at [k*(EXP_W+1) +: EXP_W+1], MSB = sign
//   i_act              LANES x ACT_W unsigned activations
//   i_skip             per-lane skip, a skipped lane contributes zero
//   i_last             final beat of the group
//   o_valid / i_ready  result handshake
//   o_result           signed saturated group sum (ACC_W)
//   o_count            beats in the group, saturating (CNT_W)
//   o_sat              accumulator clamped at least once in the group
module shift_mac_array #(
  parameter int LANES = 4,
  parameter int ACT_W = 8,
  parameter int EXP_W = 3,
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [LANES*(EXP_W+1)-1:0] i_weight,
  input  logic [LANES*ACT_W-1:0]     i_act,
  input  logic [LANES-1:0]           i_skip,
  input  logic                       i_last,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [ACC_W-1:0]           o_result,
  output logic [CNT_W-1:0]           o_count,
  output logic                       o_sat
);

  localparam int WW    = EXP_W + 1;
  localparam int PW    = ACT_W + (1 << EXP_W) - 1;
  // The lane sum is kept wide enough for 16 full-scale lanes so that a
  // narrow accumulator still sees the true beat sum and clamps correctly
  // instead of wrapping before the saturation check.
  localparam int SUM_W = PW + 5;
  localparam int S2_W  = (ACC_W > SUM_W) ? ACC_W : SUM_W;
  localparam int EXT_W = S2_W + 1;

  localparam logic signed [EXT_W-1:0] ACC_MAX_X = {{(EXT_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] ACC_MIN_X = {{(EXT_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]        CNT_MAX   = {CNT_W{1'b1}};

  logic advance;

  logic [EXP_W-1:0]        lane_exp  [LANES];
  logic [PW-1:0]           lane_mag  [LANES];
  logic signed [PW-1:0]    lane_prod [LANES];
  logic signed [S2_W-1:0]  lane_sum;

  logic                    s1_valid_d, s1_valid_q;
  logic                    s1_last_d,  s1_last_q;
  logic signed [PW-1:0]    s1_prod_d [LANES];
  logic signed [PW-1:0]    s1_prod_q [LANES];

  logic                    s2_valid_d, s2_valid_q;
  logic                    s2_last_d,  s2_last_q;
  logic signed [S2_W-1:0]  s2_sum_d,   s2_sum_q;

  logic signed [EXT_W-1:0] acc_sum;
  logic [ACC_W-1:0]        acc_next;
  logic                    acc_clamp;
  logic [CNT_W-1:0]        cnt_inc;

  logic [ACC_W-1:0]        acc_d,      acc_q;
  logic [CNT_W-1:0]        cnt_d,      cnt_q;
  logic                    sticky_d,   sticky_q;
  logic                    o_valid_d,  o_valid_q;
  logic [ACC_W-1:0]        o_result_d, o_result_q;
  logic [CNT_W-1:0]        o_count_d,  o_count_q;
  logic                    o_sat_d,    o_sat_q;

  // The whole pipeline moves only when the result register is free or
  // being drained this cycle.
  assign advance = !o_valid_q || i_ready;
  assign o_ready = advance;

  // Per-lane shift product; exponent 0 or a skipped lane yields zero.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_exp[k] = i_weight[k*WW +: EXP_W];
      lane_mag[k] = {{(PW-ACT_W){1'b0}}, i_act[k*ACT_W +: ACT_W]} << (lane_exp[k] - EXP_W'(1));
      if (lane_exp[k] == '0 || i_skip[k]) begin
        lane_prod[k] = '0;
      end else if (i_weight[k*WW + EXP_W]) begin
        lane_prod[k] = -$signed(lane_mag[k]);
      end else begin
        lane_prod[k] = $signed(lane_mag[k]);
      end
    end
  end

  // S1 next state: capture lane products of the incoming beat.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_last_d  = s1_last_q;
    for (int k = 0; k < LANES; k++) begin
      s1_prod_d[k] = s1_prod_q[k];
    end
    if (advance) begin
      s1_valid_d = i_valid;
      s1_last_d  = i_last;
      for (int k = 0; k < LANES; k++) begin
        s1_prod_d[k] = lane_prod[k];
      end
    end
  end

  // Sign-extended sum of the registered S1 products.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + {{(S2_W-PW){s1_prod_q[k][PW-1]}}, s1_prod_q[k]};
    end
  end

  // S2 next state.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_last_d  = s2_last_q;
    s2_sum_d   = s2_sum_q;
    if (advance) begin
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_sum_d   = lane_sum;
    end
  end

  // Saturating accumulate and saturating beat count.
  always_comb begin
    acc_sum   = {{(EXT_W-ACC_W){acc_q[ACC_W-1]}}, acc_q} + {s2_sum_q[S2_W-1], s2_sum_q};
    acc_clamp = 1'b0;
    acc_next  = acc_sum[ACC_W-1:0];
    if (acc_sum > ACC_MAX_X) begin
      acc_next  = ACC_MAX_X[ACC_W-1:0];
      acc_clamp = 1'b1;
    end else if (acc_sum < ACC_MIN_X) begin
      acc_next  = ACC_MIN_X[ACC_W-1:0];
      acc_clamp = 1'b1;
    end
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // S3: a last beat publishes the result and clears the group state in the
  // same cycle so the next group starts from zero with no dead cycle.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    o_valid_d  = o_valid_q;
    o_result_d = o_result_q;
    o_count_d  = o_count_q;
    o_sat_d    = o_sat_q;
    if (advance) begin
      o_valid_d = 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          o_valid_d  = 1'b1;
          o_result_d = acc_next;
          o_count_d  = cnt_inc;
          o_sat_d    = sticky_q | acc_clamp;
          acc_d      = '0;
          cnt_d      = '0;
          sticky_d   = 1'b0;
        end else begin
          acc_d    = acc_next;
          cnt_d    = cnt_inc;
          sticky_d = sticky_q | acc_clamp;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int k = 0; k < LANES; k++) begin
        s1_prod_q[k] <= '0;
      end
      s2_valid_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_sum_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      sticky_q   <= 1'b0;
      o_valid_q  <= 1'b0;
      o_result_q <= '0;
      o_count_q  <= '0;
      o_sat_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      for (int k = 0; k < LANES; k++) begin
        s1_prod_q[k] <= s1_prod_d[k];
      end
      s2_valid_q <= s2_valid_d;
      s2_last_q  <= s2_last_d;
      s2_sum_q   <= s2_sum_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      sticky_q   <= sticky_d;
      o_valid_q  <= o_valid_d;
      o_result_q <= o_result_d;
      o_count_q  <= o_count_d;
      o_sat_q    <= o_sat_d;
    end
  end

  assign o_valid  = o_valid_q;
  assign o_result = o_result_q;
  assign o_count  = o_count_q;
  assign o_sat    = o_sat_q;

endmodule

// File: tb/tb_shift_mac_array.sv
// tb_shift_mac_array
//   Drives two instances (ACC_W=32 and ACC_W=16) with the same beats and
//   compares their group results against an arithmetic reference model.
//   Expected results are queued when a last beat is accepted and popped by
//   a monitor whenever a result handshake occurs.
module tb_shift_mac_array;

  localparam int LANES = 4;

  typedef struct {
    logic [LANES*4-1:0] w;
    logic [LANES*8-1:0] act;
    logic [LANES-1:0]   skip;
    logic               last;
  } beat_t;

  typedef struct {
    longint res;
    int     cnt;
    bit     sat;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    i_valid;
  logic [LANES*4-1:0]      i_weight;
  logic [LANES*8-1:0]      i_act;
  logic [LANES-1:0]        i_skip;
  logic                    i_last;
  logic                    i_ready;

  logic                    o_ready_a, o_valid_a, o_sat_a;
  logic signed [31:0]      o_result_a;
  logic [7:0]              o_count_a;
  logic                    o_ready_b, o_valid_b, o_sat_b;
  logic signed [15:0]      o_result_b;
  logic [7:0]              o_count_b;

  int     nChecks = 0;
  int     nErrors = 0;
  bit     randReady = 1'b0;
  exp_t   q0[$];
  exp_t   q1[$];
  longint macc[2];
  int     mcnt[2];
  bit     msat[2];
  bit     holdPrev[2];
  longint prevRes[2];
  int     prevCnt[2];

  shift_mac_array #(.LANES(LANES), .ACT_W(8), .EXP_W(3), .ACC_W(32), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready_a),
    .i_weight(i_weight), .i_act(i_act), .i_skip(i_skip), .i_last(i_last),
    .o_valid(o_valid_a), .i_ready(i_ready), .o_result(o_result_a),
    .o_count(o_count_a), .o_sat(o_sat_a)
  );

  shift_mac_array #(.LANES(LANES), .ACT_W(8), .EXP_W(3), .ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready_b),
    .i_weight(i_weight), .i_act(i_act), .i_skip(i_skip), .i_last(i_last),
    .o_valid(o_valid_b), .i_ready(i_ready), .o_result(o_result_b),
    .o_count(o_count_b), .o_sat(o_sat_b)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic signed [63:0] act, input longint exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Beat value as the specification defines it: act * 2^(e-1), negated by sign.
  function automatic longint beatSum(input beat_t b);
    longint s = 0;
    longint p;
    int e;
    for (int k = 0; k < LANES; k++) begin
      e = int'(b.w[k*4 +: 3]);
      if (e == 0 || b.skip[k]) p = 0;
      else p = longint'(b.act[k*8 +: 8]) * (longint'(1) << (e - 1));
      if (b.w[k*4 + 3]) p = -p;
      s += p;
    end
    return s;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < 2; i++) begin
      macc[i] = 0;
      mcnt[i] = 0;
      msat[i] = 1'b0;
    end
  endfunction

  function automatic void modelStep(input beat_t b);
    longint s = beatSum(b);
    longint mx;
    longint a;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      mx = (longint'(1) << ((i == 0 ? 32 : 16) - 1)) - 1;
      a = macc[i] + s;
      if (a > mx) begin a = mx; msat[i] = 1'b1; end
      if (a < -mx - 1) begin a = -mx - 1; msat[i] = 1'b1; end
      macc[i] = a;
      if (mcnt[i] < 255) mcnt[i]++;
      if (b.last) begin
        e.res = macc[i];
        e.cnt = mcnt[i];
        e.sat = msat[i];
        if (i == 0) q0.push_back(e); else q1.push_back(e);
        macc[i] = 0;
        mcnt[i] = 0;
        msat[i] = 1'b0;
      end
    end
  endfunction

  // Present one beat and hold it until accepted; the model sees it only
  // once the handshake has actually happened.
  task automatic applyStimulus(input beat_t b);
    bit accepted = 1'b0;
    i_valid  = 1'b1;
    i_weight = b.w;
    i_act    = b.act;
    i_skip   = b.skip;
    i_last   = b.last;
    for (int c = 0; c < 1000 && !accepted; c++) begin
      @(negedge clk);
      accepted = o_ready_a;
      @(posedge clk);
      #1;
    end
    if (accepted) modelStep(b);
    else checkOutput("accept_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int c = 0;
    while ((q0.size() != 0 || q1.size() != 0) && c < 2000) begin
      idle(1);
      c++;
    end
    checkOutput("drain_q0", q0.size(), 0);
    checkOutput("drain_q1", q1.size(), 0);
  endtask

  function automatic beat_t uniform(input logic [7:0] a, input logic [3:0] w,
                                    input logic [LANES-1:0] sk, input logic last);
    beat_t b;
    for (int k = 0; k < LANES; k++) begin
      b.act[k*8 +: 8] = a;
      b.w[k*4 +: 4]   = w;
    end
    b.skip = sk;
    b.last = last;
    return b;
  endfunction

  function automatic beat_t randomBeat(input logic last);
    beat_t b;
    b.w    = 16'($urandom);
    b.act  = 32'($urandom);
    b.skip = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
    b.last = last;
    return b;
  endfunction

  // Monitor for one instance: pops on handshake and checks stall holding.
  task automatic monInst(input int idx, input logic v, input longint res,
                         input logic [7:0] cnt, input logic sat, input logic rdy);
    exp_t e;
    string tag = (idx == 0) ? "a" : "b";
    if (holdPrev[idx]) begin
      checkOutput({"hold_valid_", tag}, v, 1);
      checkOutput({"hold_result_", tag}, res, prevRes[idx]);
      checkOutput({"hold_count_", tag}, cnt, prevCnt[idx]);
    end
    if (v && !i_ready) checkOutput({"stall_ready_", tag}, rdy, 0);
    if (v && i_ready) begin
      if ((idx == 0 ? q0.size() : q1.size()) == 0) begin
        checkOutput({"unexpected_valid_", tag}, 1, 0);
      end else begin
        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
        checkOutput({"result_", tag}, res, e.res);
        checkOutput({"count_", tag}, cnt, e.cnt);
        checkOutput({"sat_", tag}, sat, e.sat);
      end
    end
    holdPrev[idx] = v && !i_ready;
    prevRes[idx]  = res;
    prevCnt[idx]  = int'(cnt);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      holdPrev[0] = 1'b0;
      holdPrev[1] = 1'b0;
    end else begin
      monInst(0, o_valid_a, longint'(o_result_a), o_count_a, o_sat_a, o_ready_a);
      monInst(1, o_valid_b, longint'(o_result_b), o_count_b, o_sat_b, o_ready_b);
    end
  end

  // Random downstream backpressure, changed away from the sampling edge.
  always @(posedge clk) begin
    if (randReady) begin
      #1;
      i_ready = ($urandom_range(0, 9) < 7);
    end
  end

  initial begin
    beat_t b;
    logic v1, v2, v3;
    reset    = 1'b1;
    i_valid  = 1'b0;
    i_weight = '0;
    i_act    = '0;
    i_skip   = '0;
    i_last   = 1'b0;
    i_ready  = 1'b1;
    modelClear();
    idle(3);
    @(negedge clk);
    checkOutput("reset_valid", o_valid_a, 0);
    checkOutput("reset_result", o_result_a, 0);
    checkOutput("reset_count", o_count_a, 0);
    checkOutput("reset_sat", o_sat_a, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Single-lane beat, other lanes exponent 0, result three cycles later.
    $display("[TB] single beat latency");
    b = uniform(8'd77, 4'b1000, 4'b0000, 1'b1);
    b.act[7:0] = 8'd200;
    b.w[3:0]   = 4'b0111;
    applyStimulus(b);
    @(negedge clk); v1 = o_valid_a;
    @(negedge clk); v2 = o_valid_a;
    @(negedge clk); v3 = o_valid_a;
    checkOutput("latency_c1", v1, 0);
    checkOutput("latency_c2", v2, 0);
    checkOutput("latency_c3", v3, 1);
    @(posedge clk);
    #1;
    drain();

    // Negated lane plus a positive lane.
    b = uniform(8'd0, 4'b0000, 4'b0000, 1'b1);
    b.act[7:0]  = 8'd10;
    b.w[3:0]    = 4'b1010;
    b.act[15:8] = 8'd3;
    b.w[7:4]    = 4'b0001;
    applyStimulus(b);

    // Skipped lanes over a three-beat group, then a fresh one-beat group.
    for (int j = 0; j < 3; j++) applyStimulus(uniform(8'd255, 4'b0111, 4'b0101, j == 2));
    applyStimulus(uniform(8'd1, 4'b0001, 4'b0000, 1'b1));

    // Narrow accumulator saturates; the next group must start clean.
    for (int j = 0; j < 3; j++) applyStimulus(uniform(8'd255, 4'b0111, 4'b0000, j == 2));
    applyStimulus(uniform(8'd2, 4'b1011, 4'b0000, 1'b1));
    drain();

    // Backpressure: results must hold and emerge in order after release.
    $display("[TB] backpressure");
    i_ready = 1'b0;
    fork
      begin
        for (int n = 0; n < 6; n++) applyStimulus(randomBeat(1'b1));
      end
      begin
        idle(25);
        i_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a group discards it.
    $display("[TB] mid-group reset");
    applyStimulus(uniform(8'd100, 4'b0110, 4'b0000, 1'b0));
    applyStimulus(uniform(8'd100, 4'b0110, 4'b0000, 1'b0));
    reset = 1'b1;
    modelClear();
    idle(1);
    reset = 1'b0;
    idle(10);
    b = uniform(8'd0, 4'b0000, 4'b0000, 1'b1);
    b.act[7:0] = 8'd5;
    b.w[3:0]   = 4'b0001;
    applyStimulus(b);
    drain();

    // Randomised groups with bubbles and random backpressure.
    $display("[TB] random groups");
    randReady = 1'b1;
    for (int g = 0; g < 60; g++) begin
      int len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        applyStimulus(randomBeat(j == len - 1));
        idle($urandom_range(0, 2));
      end
    end

    // One long group to reach the beat-counter ceiling.
    for (int j = 0; j < 300; j++) applyStimulus(randomBeat(j == 299));
    randReady = 1'b0;
    idle(1);
    i_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
